// File: rtl/spi_regfile_responder.sv
// SPI mode-0 register-file responder, oversampled in the clk domain.
// Optional macro SPI_SEQOP_EN enables address auto-increment within a burst.
module spi_regfile_responder #(
  parameter int unsigned NUM_REGS    = 22,
  parameter logic [6:0]  DEV_OPCODE  = 7'h20,
  parameter logic [7:0]  RST_VAL     = 8'h00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_i,
  input  logic                  csn_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_stb_o,
  output logic [7:0]            wr_addr_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {StIdle, StOpcode, StAddr, StWrite, StRead, StIgnore} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   sclk_s, csn_s, mosi_s, sclk_rise, sclk_fall;

  state_e                   state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [6:0]               rx_q, rx_d;
  logic [7:0]               rx_byte;
  logic [7:0]               tx_q, tx_d;
  logic                     rw_q, rw_d;
  logic [7:0]               addr_q, addr_d;
  logic                     miso_q, miso_d;
  logic                     wr_stb_q, wr_stb_d;
  logic [7:0]               wr_addr_q, wr_addr_d;
  logic [NUM_REGS-1:0][7:0] regs_q, regs_d;

  function automatic logic [7:0] rd_data(input logic [NUM_REGS-1:0][7:0] rf,
                                         input logic [7:0] a);
    rd_data = 8'h00;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (a == 8'(i)) rd_data = rf[i];
    end
  endfunction

  function automatic logic [7:0] next_addr(input logic [7:0] a);
`ifdef SPI_SEQOP_EN
    next_addr = (a == 8'(NUM_REGS - 1)) ? 8'h00 : a + 8'h01;
`else
    next_addr = a;
`endif
  endfunction

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], csn_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    csn_s       = csn_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_dly_d  = sclk_s;
    sclk_rise   = sclk_s & ~sclk_dly_q;
    sclk_fall   = ~sclk_s & sclk_dly_q;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    regs_d    = regs_q;
    rx_byte   = {rx_q, mosi_s};

    // csn high takes priority over any coincident sclk event.
    if (csn_s) begin
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      rx_d      = 7'd0;
      tx_d      = 8'd0;
      miso_d    = 1'b0;
    end else if (state_q == StIdle) begin
      state_d = StOpcode;
    end else begin
      if (sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_d      = rx_byte[6:0];
        if (bit_cnt_q == 3'd7) begin
          unique case (state_q)
            StOpcode: begin
              rw_d    = rx_byte[0];
              state_d = (rx_byte[7:1] == DEV_OPCODE) ? StAddr : StIgnore;
            end
            StAddr: begin
              addr_d = rx_byte;
              if (rw_q) begin
                state_d = StRead;
                tx_d    = rd_data(regs_q, rx_byte);
              end else begin
                state_d = StWrite;
              end
            end
            StWrite: begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (addr_q == 8'(i)) regs_d[i] = rx_byte;
              end
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
              addr_d    = next_addr(addr_q);
            end
            StRead: begin
              addr_d = next_addr(addr_q);
              tx_d   = rd_data(regs_q, next_addr(addr_q));
            end
            default: ;
          endcase
        end
      end
      if (sclk_fall && state_q == StRead) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'd0;
      rw_q        <= 1'b0;
      addr_q      <= 8'd0;
      miso_q      <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 8'd0;
      regs_q      <= {NUM_REGS{RST_VAL}};
    end else begin
      sclk_sync_q <= sclk_sync_d;
      csn_sync_q  <= csn_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  assign miso_o    = miso_q;
  assign regs_o    = regs_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_addr_o = wr_addr_q;
  assign busy_o    = ~csn_s;

endmodule

// File: tb/tb_spi_regfile_responder.sv
// Directed bench for spi_regfile_responder; expectations follow SPI_SEQOP_EN if defined.
module tb_spi_regfile_responder;

  localparam int unsigned NumRegs = 22;
  localparam int          Half    = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sclk_i = 1'b0;
  logic                 csn_i = 1'b1;
  logic                 mosi_i = 1'b0;
  logic                 miso_o;
  logic [NumRegs*8-1:0] regs_o;
  logic                 wr_stb_o;
  logic [7:0]           wr_addr_o;
  logic                 busy_o;

  spi_regfile_responder #(
    .NUM_REGS   (NumRegs),
    .DEV_OPCODE (7'h20),
    .RST_VAL    (8'h00),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk_i   (sclk_i),
    .csn_i    (csn_i),
    .mosi_i   (mosi_i),
    .miso_o   (miso_o),
    .regs_o   (regs_o),
    .wr_stb_o (wr_stb_o),
    .wr_addr_o(wr_addr_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] stb_q[$];
  logic       miso_seen = 1'b0;

  always @(negedge clk) begin
    if (wr_stb_o) stb_q.push_back(wr_addr_o);
    if (miso_o) miso_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] reg_at(input int n);
    return regs_o[8*n +: 8];
  endfunction

  task automatic spi_bit(input logic b, output logic r);
    mosi_i = b;
    repeat (Half) @(negedge clk);
    r = miso_o;
    sclk_i = 1'b1;
    repeat (Half) @(negedge clk);
    sclk_i = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) spi_bit(b[i], r[i]);
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    spi_bits(b, 8, r);
  endtask

  task automatic frame_start();
    stb_q.delete();
    csn_i = 1'b0;
    repeat (Half) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (Half) @(negedge clk);
    csn_i = 1'b1;
    repeat (2 * Half) @(negedge clk);
  endtask

  task automatic write3(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    frame_start();
    spi_byte(8'h40, r);
    spi_byte(a, r);
    spi_byte(d, r);
    frame_end();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]           r, r2;
    logic [NumRegs*8-1:0] snap;

    repeat (3) @(negedge clk);
    check_eq("rst_miso", {31'b0, miso_o}, 32'd0);
    check_eq("rst_busy", {31'b0, busy_o}, 32'd0);
    check_eq("rst_stb", {31'b0, wr_stb_o}, 32'd0);
    check_eq("rst_wr_addr", {24'b0, wr_addr_o}, 32'd0);
    check_eq("rst_regs", {31'b0, regs_o == '0}, 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Read of a reset register
    frame_start();
    check_eq("busy_in_frame", {31'b0, busy_o}, 32'd1);
    spi_byte(8'h41, r);
    spi_byte(8'h05, r);
    spi_byte(8'hFF, r);
    frame_end();
    check_eq("rd_rst_val", {24'b0, r}, 32'h00);
    check_eq("rd_no_stb", stb_q.size(), 32'd0);
    check_eq("rd_regs_same", {31'b0, regs_o == '0}, 32'd1);
    check_eq("busy_after", {31'b0, busy_o}, 32'd0);

    // Two-byte burst write
    frame_start();
    spi_byte(8'h40, r);
    spi_byte(8'h03, r);
    spi_byte(8'hA5, r);
    spi_byte(8'h5A, r);
    frame_end();
    check_eq("bw_stb_cnt", stb_q.size(), 32'd2);
    check_eq("bw_stb_a0", {24'b0, stb_q[0]}, 32'd3);
`ifdef SPI_SEQOP_EN
    check_eq("bw_reg3", {24'b0, reg_at(3)}, 32'hA5);
    check_eq("bw_reg4", {24'b0, reg_at(4)}, 32'h5A);
    check_eq("bw_stb_a1", {24'b0, stb_q[1]}, 32'd4);
`else
    check_eq("bw_reg3", {24'b0, reg_at(3)}, 32'h5A);
    check_eq("bw_reg4", {24'b0, reg_at(4)}, 32'h00);
    check_eq("bw_stb_a1", {24'b0, stb_q[1]}, 32'd3);
`endif

    // Two-byte burst read back
    frame_start();
    spi_byte(8'h41, r);
    spi_byte(8'h03, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r2);
    frame_end();
`ifdef SPI_SEQOP_EN
    check_eq("br_b0", {24'b0, r}, 32'hA5);
    check_eq("br_b1", {24'b0, r2}, 32'h5A);
`else
    check_eq("br_b0", {24'b0, r}, 32'h5A);
    check_eq("br_b1", {24'b0, r2}, 32'h5A);
`endif

    // Burst write across the last register
    frame_start();
    spi_byte(8'h40, r);
    spi_byte(8'h15, r);
    spi_byte(8'h11, r);
    spi_byte(8'h22, r);
    frame_end();
    check_eq("wrap_stb_cnt", stb_q.size(), 32'd2);
`ifdef SPI_SEQOP_EN
    check_eq("wrap_reg21", {24'b0, reg_at(21)}, 32'h11);
    check_eq("wrap_reg0", {24'b0, reg_at(0)}, 32'h22);
    check_eq("wrap_stb_a1", {24'b0, stb_q[1]}, 32'd0);
`else
    check_eq("wrap_reg21", {24'b0, reg_at(21)}, 32'h22);
    check_eq("wrap_reg0", {24'b0, reg_at(0)}, 32'h00);
    check_eq("wrap_stb_a1", {24'b0, stb_q[1]}, 32'd21);
`endif

    // Foreign device opcode is ignored
    snap = regs_o;
    miso_seen = 1'b0;
    frame_start();
    spi_byte(8'h4E, r);
    spi_byte(8'h00, r);
    spi_byte(8'hFF, r);
    frame_end();
    check_eq("ign_regs", {31'b0, regs_o == snap}, 32'd1);
    check_eq("ign_no_stb", stb_q.size(), 32'd0);
    check_eq("ign_miso", {31'b0, miso_seen}, 32'd0);

    // Out-of-range write is dropped but still strobed; read returns 0
    snap = regs_o;
    write3(8'h30, 8'hEE);
    check_eq("oor_regs", {31'b0, regs_o == snap}, 32'd1);
    check_eq("oor_stb_cnt", stb_q.size(), 32'd1);
    check_eq("oor_stb_a", {24'b0, stb_q[0]}, 32'h30);
    frame_start();
    spi_byte(8'h41, r);
    spi_byte(8'h30, r);
    spi_byte(8'h00, r);
    frame_end();
    check_eq("oor_rd", {24'b0, r}, 32'h00);

    // Aborted data byte is not committed; next frame decodes normally
    write3(8'h02, 8'h3C);
    check_eq("pre_abort_reg2", {24'b0, reg_at(2)}, 32'h3C);
    frame_start();
    spi_byte(8'h40, r);
    spi_byte(8'h02, r);
    spi_bits(8'hC3, 5, r);
    frame_end();
    check_eq("abort_reg2", {24'b0, reg_at(2)}, 32'h3C);
    check_eq("abort_no_stb", stb_q.size(), 32'd0);
    write3(8'h02, 8'h96);
    check_eq("post_abort_reg2", {24'b0, reg_at(2)}, 32'h96);

    // Reset in the middle of a read burst
    frame_start();
    spi_byte(8'h41, r);
    spi_byte(8'h03, r);
    spi_byte(8'h00, r);
`ifdef SPI_SEQOP_EN
    check_eq("mid_rd_b0", {24'b0, r}, 32'hA5);
`else
    check_eq("mid_rd_b0", {24'b0, r}, 32'h5A);
`endif
    spi_bits(8'h00, 4, r);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_miso", {31'b0, miso_o}, 32'd0);
    check_eq("midrst_busy", {31'b0, busy_o}, 32'd0);
    check_eq("midrst_regs", {31'b0, regs_o == '0}, 32'd1);
    csn_i = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    frame_start();
    spi_byte(8'h41, r);
    spi_byte(8'h03, r);
    spi_byte(8'h00, r);
    frame_end();
    check_eq("post_rst_rd", {24'b0, r}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
